// File: rtl/wb_tlc_cr_arb.sv
// Round-robin arbiter that turns control-register requests into single cr_wb
// strobes, each followed by a guard interval for the wb_clk->clk_125 crossing.
module wb_tlc_cr_arb #(
  parameter int NREQ = 4,
  parameter int SW   = 2,
  parameter int DW   = 16,
  parameter int GAP  = 8
) (
  input  logic              wb_clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              cr_wb,
  output logic [DW-1:0]     cr_data,
  output logic [SW-1:0]     cr_sel,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t          state;
  logic [SW-1:0]   ptr;
  logic [SW-1:0]   win;
  logic [7:0]      cnt;

  logic            found;
  logic [SW-1:0]   pick;
  logic [DW-1:0]   pick_data;
  int unsigned     idx;

  // First set request searching upward from ptr, wrapping at NREQ.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_data = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick      = SW'(idx);
        pick_data = req_data[idx*DW +: DW];
      end
    end
  end

  always_ff @(posedge wb_clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      cr_wb   <= 1'b0;
      cr_data <= '0;
      cr_sel  <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && found) begin
            cr_data <= pick_data;
            cr_sel  <= pick;
            win     <= pick;
            gnt     <= NREQ'(1) << pick;
            cr_wb   <= 1'b1;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          gnt   <= '0;
          cr_wb <= 1'b0;
          ptr   <= (win == SW'(NREQ - 1)) ? '0 : win + 1'b1;
          cnt   <= 8'(GAP - 1);
          state <= HOLD;
        end
        HOLD: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_tlc_cr_arb.sv
// Directed bench for wb_tlc_cr_arb: 4-source default build plus a 3-source
// build checking the pointer wraps at NREQ.
module tb_wb_tlc_cr_arb;

  localparam int GAP = 8;

  logic        wb_clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic        cr_wb;
  logic [15:0] cr_data;
  logic [1:0]  cr_sel;
  logic        busy;

  logic        en3;
  logic [2:0]  req3;
  logic [47:0] req_data3;
  logic [2:0]  gnt3;
  logic        cr_wb3;
  logic [15:0] cr_data3;
  logic [1:0]  cr_sel3;
  logic        busy3;

  logic [15:0] dat [4];
  logic [15:0] dat3 [3];

  int total = 0;
  int bad   = 0;

  always #5 wb_clk = ~wb_clk;

  wb_tlc_cr_arb #(.NREQ(4), .SW(2), .DW(16), .GAP(GAP)) dut (
    .wb_clk(wb_clk), .rstn(rstn), .en(en), .req(req), .req_data(req_data),
    .gnt(gnt), .cr_wb(cr_wb), .cr_data(cr_data), .cr_sel(cr_sel), .busy(busy)
  );

  wb_tlc_cr_arb #(.NREQ(3), .SW(2), .DW(16), .GAP(4)) dut3 (
    .wb_clk(wb_clk), .rstn(rstn), .en(en3), .req(req3), .req_data(req_data3),
    .gnt(gnt3), .cr_wb(cr_wb3), .cr_data(cr_data3), .cr_sel(cr_sel3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Negedges until cr_wb is seen high (1 = the very next negedge).
  task automatic wait_strobe(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge wb_clk);
      if (cr_wb) begin
        cyc = n;
        return;
      end
    end
    check("strobe_timeout", 32'(cr_wb), 32'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      @(negedge wb_clk);
      if (!busy) return;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int cnt;
    int exp_src;

    dat[0] = 16'hA0A0; dat[1] = 16'hB1B1; dat[2] = 16'h1234; dat[3] = 16'hD3D3;
    dat3[0] = 16'h1111; dat3[1] = 16'h2222; dat3[2] = 16'h3333;
    req_data  = {dat[3], dat[2], dat[1], dat[0]};
    req_data3 = {dat3[2], dat3[1], dat3[0]};
    rstn = 1'b0; en = 1'b0; req = '0; en3 = 1'b0; req3 = '0;

    repeat (3) @(negedge wb_clk);
    check("rst_cr_wb", 32'(cr_wb), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_cr_data", 32'(cr_data), 0);
    check("rst_cr_sel", 32'(cr_sel), 0);
    check("rst_busy", 32'(busy), 0);
    rstn = 1'b1;
    @(negedge wb_clk);

    // Single request from source 2
    en = 1'b1; req = 4'b0100;
    wait_strobe(cyc);
    check("t1_latency", 32'(cyc), 1);
    check("t1_gnt", 32'(gnt), 32'h4);
    check("t1_cr_data", 32'(cr_data), 32'h1234);
    check("t1_cr_sel", 32'(cr_sel), 2);
    req = '0;
    cnt = 0;
    for (int n = 0; n < 40 && busy; n++) begin
      cnt++;
      @(negedge wb_clk);
    end
    check("t1_busy_len", 32'(cnt), GAP + 1);

    // ptr=3, sources 0 and 2: wrap to 0 first, then 2
    req = 4'b0101;
    wait_strobe(cyc);
    check("t3_gnt_wrap", 32'(gnt), 32'h1);
    check("t3_sel_wrap", 32'(cr_sel), 0);
    wait_strobe(cyc);
    check("t3_spacing", 32'(cyc), GAP + 2);
    check("t3_gnt_next", 32'(gnt), 32'h4);

    // All four requesting: rotation from ptr=3
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      exp_src = (3 + k) % 4;
      wait_strobe(cyc);
      check("t2_spacing", 32'(cyc), GAP + 2);
      check("t2_gnt", 32'(gnt), 32'(1 << exp_src));
      check("t2_sel", 32'(cr_sel), 32'(exp_src));
      check("t2_data", 32'(cr_data), 32'(dat[exp_src]));
    end
    req = '0;
    wait_idle();

    // Enable gating
    en = 1'b0; req = 4'b0010;
    cnt = 0;
    repeat (20) begin
      @(negedge wb_clk);
      if (cr_wb) cnt++;
    end
    check("t4_no_issue_en0", 32'(cnt), 0);
    en = 1'b1;
    wait_strobe(cyc);
    check("t4_en_latency", 32'(cyc), 1);
    check("t4_gnt", 32'(gnt), 32'h2);
    en = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge wb_clk);
      if (cr_wb) cnt++;
    end
    check("t4_no_issue_after_hold", 32'(cnt), 0);
    check("t4_busy_done", 32'(busy), 0);
    en = 1'b1;
    wait_strobe(cyc);
    check("t4_reen_latency", 32'(cyc), 1);
    check("t4_reen_gnt", 32'(gnt), 32'h2);
    req = '0;
    wait_idle();

    // Withdrawn request is never granted
    en = 1'b0; req = 4'b0001;
    repeat (3) @(negedge wb_clk);
    req = '0;
    repeat (2) @(negedge wb_clk);
    req = 4'b1000; en = 1'b1;
    wait_strobe(cyc);
    check("t5_latency", 32'(cyc), 1);
    check("t5_gnt", 32'(gnt), 32'h8);
    check("t5_data", 32'(cr_data), 32'(dat[3]));
    req = '0;
    wait_idle();

    // Reset during HOLD with requests pending
    req = 4'b0110;
    wait_strobe(cyc);
    repeat (3) @(negedge wb_clk);
    check("t6_busy_hold", 32'(busy), 1);
    rstn = 1'b0;
    #1;
    check("t6_rst_cr_wb", 32'(cr_wb), 0);
    check("t6_rst_gnt", 32'(gnt), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_cr_data", 32'(cr_data), 0);
    check("t6_rst_cr_sel", 32'(cr_sel), 0);
    @(negedge wb_clk);
    rstn = 1'b1;
    wait_strobe(cyc);
    check("t6_post_latency", 32'(cyc), 1);
    check("t6_post_gnt", 32'(gnt), 32'h2);
    check("t6_post_sel", 32'(cr_sel), 1);
    req = '0; en = 1'b0;
    wait_idle();

    // NREQ=3 build: rotation 0,1,2,0,... never index 3
    req3 = 3'b111; en3 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      exp_src = k % 3;
      cyc = -1;
      for (int n = 1; n <= 40; n++) begin
        @(negedge wb_clk);
        if (cr_wb3) begin
          cyc = n;
          break;
        end
      end
      if (cyc < 0) check("n3_timeout", 32'(cr_wb3), 1);
      if (k > 0) check("n3_spacing", 32'(cyc), 6);
      check("n3_sel", 32'(cr_sel3), 32'(exp_src));
      check("n3_gnt", 32'(gnt3), 32'(1 << exp_src));
      check("n3_data", 32'(cr_data3), 32'(dat3[exp_src]));
    end
    req3 = '0; en3 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_tlc_cr_arb.md
# wb_tlc_cr_arb

Wishbone-domain arbiter and sequencer for the shared wb_clk→clk_125 control-strobe crossing. It collects level requests from up to NREQ control-register sources, grants one at a time in round-robin order, and issues a single one-cycle cr_wb pulse with its payload held stable. It then enforces a guard interval so the downstream pulse stretcher and 125 MHz synchronizer capture every strobe exactly once. It sits between the WB register file and the strobe synchronizer feeding the TLC.

## Interface
- NREQ, 4, number of requesters (2..8)
- SW, 2, width of cr_sel; must satisfy 2^SW >= NREQ
- DW, 16, payload width per requester
- GAP, 8, guard cycles after each issue before the next may start (4..255)

- wb_clk  in  1  Wishbone clock; all logic on rising edge
- rstn  in  1  reset: asynchronous, active-low; clock wb_clk
- en  in  1  arbitration enable; low blocks new issues only
- req  in  NREQ  level request per source, bit i = source i
- req_data  in  NREQ*DW  payload; source i in bits [i*DW +: DW]
- gnt  out  NREQ  one-cycle grant pulse, one-hot or zero
- cr_wb  out  1  one-cycle strobe to the synchronizer
- cr_data  out  DW  payload of the last issue, held until the next issue
- cr_sel  out  SW  index of the last granted source, held with cr_data
- busy  out  1  high in ISSUE and HOLD

## Operation
- States: IDLE, ISSUE, HOLD. Reset → IDLE.
- IDLE: if en=1 and req≠0, pick winner w, the first set req bit searching upward from ptr with wrap to 0. Register cr_data←req_data[w], cr_sel←w, and latch w. Next state is ISSUE. If en=0 or req=0, stay in IDLE.
- ISSUE (exactly 1 cycle): cr_wb=1, gnt[w]=1, ptr←(w+1) mod NREQ, counter←GAP-1. Next state is HOLD.
- HOLD: decrement counter each cycle. When counter=0, go to IDLE. req and en are ignored in HOLD.
- Requester rules:
  - Hold req and req_data stable until gnt.
  - Deassert req in the cycle after gnt, or leave it high to request again. A still-high req counts as a new request at its round-robin turn.
  - Dropping req before gnt withdraws the request. This is legal only while the arbiter is not in ISSUE.
- Fairness: with all NREQ requesting continuously, each source gets exactly one grant per NREQ issues.
- cr_data and cr_sel change only on the IDLE→ISSUE transition. They are stable from one cr_wb through the start of the next.
- en deasserted during ISSUE or HOLD: the current sequence completes normally. The arbiter then waits in IDLE until en returns.
- Counter is 8 bits. ptr is SW bits and wraps at NREQ, not at 2^SW.

## Timing
- Reset values: gnt=0, cr_wb=0, cr_data=0, cr_sel=0, busy=0, ptr=0, counter=0, state=IDLE.
- All outputs are registered. There is no combinational path from req or en to any output.
- Latency: req sampled high in IDLE at edge k gives cr_wb, gnt, and busy high in cycle k+1. cr_data and cr_sel are valid from cycle k+1.
- Issue period: ISSUE(1) + HOLD(GAP) + IDLE(1) = GAP+2 wb_clk cycles minimum between cr_wb pulses.
- GAP ≥ 4 guarantees a separate 125 MHz edge detect per strobe when clk_125 ≥ wb_clk. This is a parameter constraint; the block does not check it.
- Simultaneous requests are resolved in one cycle by rotating priority. There is no idle bubble beyond the single IDLE cycle.
- Asynchronous reset mid-ISSUE or mid-HOLD drops cr_wb and gnt immediately, returns to IDLE, and resets ptr to 0. A pulse already sent is not replayed.

## Test plan
- Reset, then req=4'b0100 with data 0x1234 → cr_wb and gnt=4'b0100 one cycle later. cr_data=0x1234, cr_sel=2, busy for GAP+1 cycles, next issue no earlier than GAP+2 cycles after.
- req=4'b1111 held, distinct data per source → grants in order 0,1,2,3,0,… with cr_wb spaced exactly GAP+2 cycles and cr_data matching each grantee.
- ptr=3 (after granting source 2), req=4'b0101 → grant source 0 (wrap), then source 2. NREQ=3 build: ptr wraps 2→0, never 3.
- en=0 with req=4'b0010 → no cr_wb. Drop en during HOLD → HOLD completes and no new issue. Raise en → issue within 1 cycle.
- Request withdrawn in IDLE before the winner is chosen → no gnt, no cr_wb. Next pending source is served normally.
- Assert rstn low during HOLD with a pending request → all outputs 0 immediately. After release, the first grant goes to the lowest pending index.
